// File: rtl/stage_sequencer_if.sv
// Signal bundle between the stage sequencer and the rest of the game logic.
// boss_hit and enma_spawn are single-cycle strobes; start and player_dead are levels.
interface stage_sequencer_if;
    logic       start;
    logic [3:0] enma_alive;
    logic       boss_hit;
    logic [3:0] hit_dmg;
    logic       player_dead;
    logic [3:0] enma_spawn;
    logic [9:0] bosshp;
    logic [1:0] boss_phase;
    logic       boss_fire;
    logic [2:0] state;
    logic       stage_clear;
    logic       game_over;

    modport master (
        output start, enma_alive, boss_hit, hit_dmg, player_dead,
        input  enma_spawn, bosshp, boss_phase, boss_fire, state, stage_clear, game_over
    );

    modport slave (
        input  start, enma_alive, boss_hit, hit_dmg, player_dead,
        output enma_spawn, bosshp, boss_phase, boss_fire, state, stage_clear, game_over
    );
endinterface

// File: rtl/stage_sequencer.sv
// Stage controller: enemy waves, boss intro, boss fight with HP register and
// phase-dependent fire scheduling. The FSM state is exposed on bus.state.
module stage_sequencer #(
    parameter int WAVES        = 3,
    parameter int BOSS_HP_INIT = 450,
    parameter int INTRO_TICKS  = 32,
    parameter int FIRE_P1      = 16,
    parameter int FIRE_P2      = 10,
    parameter int FIRE_P3      = 6
) (
    input  logic               clk22,
    input  logic               rst,
    stage_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAVE  = 3'd1,
        S_INTRO = 3'd2,
        S_BOSS  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [3:0]  LAST_WAVE  = 4'(WAVES - 1);
    localparam logic [9:0]  HP_INIT    = 10'(BOSS_HP_INIT);
    localparam logic [15:0] INTRO_LAST = 16'(INTRO_TICKS - 1);
    localparam logic [7:0]  P1_M1      = 8'(FIRE_P1 - 1);
    localparam logic [7:0]  P2_M1      = 8'(FIRE_P2 - 1);
    localparam logic [7:0]  P3_M1      = 8'(FIRE_P3 - 1);

    state_t      state_q, state_n;
    logic [3:0]  wave_q, wave_n;
    logic [1:0]  guard_q, guard_n;
    logic [15:0] intro_q, intro_n;
    logic [7:0]  fcnt_q, fcnt_n;
    logic [9:0]  hp_q, hp_n;
    logic [3:0]  spawn_q, spawn_n;
    logic        fire_q, fire_n;
    logic        clear_q, over_q;
    logic [9:0]  hit_hp, boss_hp;

    function automatic logic [1:0] phase_of(input logic [9:0] hp);
        if (hp == 10'd0)        return 2'd0;
        else if (hp > 10'd300)  return 2'd1;
        else if (hp > 10'd150)  return 2'd2;
        else                    return 2'd3;
    endfunction

    function automatic logic [7:0] period_m1(input logic [1:0] ph);
        case (ph)
            2'd1:    return P1_M1;
            2'd2:    return P2_M1;
            default: return P3_M1;
        endcase
    endfunction

    // Saturating subtract so HP never wraps below zero.
    assign hit_hp  = (hp_q > {6'd0, bus.hit_dmg}) ? hp_q - {6'd0, bus.hit_dmg} : 10'd0;
    assign boss_hp = bus.boss_hit ? hit_hp : hp_q;

    always_comb begin
        state_n = state_q;
        wave_n  = wave_q;
        guard_n = guard_q;
        intro_n = intro_q;
        fcnt_n  = fcnt_q;
        hp_n    = hp_q;
        spawn_n = 4'h0;
        fire_n  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_WAVE;
                    wave_n  = 4'd0;
                    guard_n = 2'd2;
                    spawn_n = 4'hF;
                    hp_n    = 10'd0;
                end
            end
            S_WAVE: begin
                if (bus.player_dead) begin
                    state_n = S_OVER;
                end else if (guard_q != 2'd0) begin
                    guard_n = guard_q - 2'd1;
                end else if (bus.enma_alive == 4'h0) begin
                    if (wave_q == LAST_WAVE) begin
                        state_n = S_INTRO;
                        hp_n    = HP_INIT;
                        intro_n = 16'd0;
                    end else begin
                        wave_n  = wave_q + 4'd1;
                        guard_n = 2'd2;
                        spawn_n = 4'hF;
                    end
                end
            end
            S_INTRO: begin
                if (bus.player_dead) begin
                    state_n = S_OVER;
                end else if (intro_q == INTRO_LAST) begin
                    state_n = S_BOSS;
                    fcnt_n  = 8'd0;
                end else begin
                    intro_n = intro_q + 16'd1;
                end
            end
            S_BOSS: begin
                // A hit landing with player_dead still counts; OVER then holds it.
                hp_n = boss_hp;
                if (bus.player_dead) begin
                    state_n = S_OVER;
                end else if (boss_hp == 10'd0) begin
                    state_n = S_CLEAR;
                end else if (phase_of(boss_hp) != phase_of(hp_q)) begin
                    fcnt_n = 8'd0;
                end else if (fcnt_q == period_m1(phase_of(hp_q))) begin
                    fcnt_n = 8'd0;
                    fire_n = 1'b1;
                end else begin
                    fcnt_n = fcnt_q + 8'd1;
                end
            end
            S_CLEAR: begin
                hp_n = 10'd0;
                if (bus.start) state_n = S_IDLE;
            end
            S_OVER: begin
                if (bus.start) begin
                    state_n = S_IDLE;
                    hp_n    = 10'd0;
                end
            end
            default: begin
                state_n = S_IDLE;
                hp_n    = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wave_q  <= 4'd0;
            guard_q <= 2'd0;
            intro_q <= 16'd0;
            fcnt_q  <= 8'd0;
            hp_q    <= 10'd0;
            spawn_q <= 4'h0;
            fire_q  <= 1'b0;
            clear_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            wave_q  <= wave_n;
            guard_q <= guard_n;
            intro_q <= intro_n;
            fcnt_q  <= fcnt_n;
            hp_q    <= hp_n;
            spawn_q <= spawn_n;
            fire_q  <= fire_n;
            clear_q <= (state_n == S_CLEAR);
            over_q  <= (state_n == S_OVER);
        end
    end

    assign bus.state       = state_q;
    assign bus.bosshp      = hp_q;
    assign bus.enma_spawn  = spawn_q;
    assign bus.boss_fire   = fire_q;
    assign bus.stage_clear = clear_q;
    assign bus.game_over   = over_q;
    assign bus.boss_phase  = (state_q == S_INTRO || state_q == S_BOSS) ? phase_of(hp_q) : 2'd0;
endmodule
